// File: rtl/tc_register_bank.sv
// rtl/tc_register_bank.sv - DEPTH x WIDTH register file, one write port, two gated read ports
// Optional write-through forwarding to the read ports is enabled by defining TC_REGBANK_BYPASS_EN.
module tc_register_bank #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter bit ZERO_REG = 1'b0,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             save,
   input  logic [AW-1:0]    save_addr,
   input  logic [WIDTH-1:0] in,
   input  logic             clear,
   input  logic             load_a,
   input  logic [AW-1:0]    addr_a,
   output logic [WIDTH-1:0] out_a,
   input  logic             load_b,
   input  logic [AW-1:0]    addr_b,
   output logic [WIDTH-1:0] out_b,
   output logic [7:0]       wr_count
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [7:0]       wr_count_q;
   logic [7:0]       wr_count_d;
   logic             wr_accept;
   logic             rd_ok_a;
   logic             rd_ok_b;

   // Out-of-range addresses and the hardwired-zero slot never hold data.
   assign wr_accept = save && !clear && !rst && ({1'b0, save_addr} < DEPTH_W)
                      && !(ZERO_REG && save_addr == '0);
   assign rd_ok_a   = ({1'b0, addr_a} < DEPTH_W) && !(ZERO_REG && addr_a == '0);
   assign rd_ok_b   = ({1'b0, addr_b} < DEPTH_W) && !(ZERO_REG && addr_b == '0);
   assign wr_count  = wr_count_q;

   always_comb begin
      regs_d     = regs_q;
      wr_count_d = wr_count_q;
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
         wr_count_d = '0;
      end else if (wr_accept) begin
         regs_d[save_addr] = in;
         if (wr_count_q != 8'hFF) wr_count_d = wr_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         wr_count_q <= '0;
      end else begin
         regs_q     <= regs_d;
         wr_count_q <= wr_count_d;
      end
   end

   always_comb begin
      out_a = '0;
      if (load_a && rd_ok_a) out_a = regs_q[addr_a];
`ifdef TC_REGBANK_BYPASS_EN
      // Forward the value the coming edge will store, including a pending clear.
      if (load_a && clear && !rst) out_a = '0;
      else if (load_a && wr_accept && addr_a == save_addr) out_a = in;
`endif
   end

   always_comb begin
      out_b = '0;
      if (load_b && rd_ok_b) out_b = regs_q[addr_b];
`ifdef TC_REGBANK_BYPASS_EN
      if (load_b && clear && !rst) out_b = '0;
      else if (load_b && wr_accept && addr_b == save_addr) out_b = in;
`endif
   end

endmodule

// File: tb/tb_tc_register_bank.sv
// tb/tb_tc_register_bank.sv - directed bench for tc_register_bank with an array-based reference model
// Two instances: dut0 (DEPTH 8, ordinary r0) and dut1 (DEPTH 6, hardwired-zero r0) share stimulus.
module tb_tc_register_bank;

   logic       clk = 1'b0;
   logic       rst, save, clear, load_a, load_b;
   logic [2:0] save_addr, addr_a, addr_b;
   logic [7:0] wdata;
   logic [7:0] out_a0, out_b0, wr_count0, out_a1, out_b1, wr_count1;

   int checks = 0;
   int errors = 0;

   logic [7:0] m0 [8];
   logic [7:0] m1 [6];
   int c0, c1;

   always #5 clk = ~clk;

   tc_register_bank #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0)) dut0 (
      .clk(clk), .rst(rst), .save(save), .save_addr(save_addr), .in(wdata), .clear(clear),
      .load_a(load_a), .addr_a(addr_a), .out_a(out_a0),
      .load_b(load_b), .addr_b(addr_b), .out_b(out_b0), .wr_count(wr_count0)
   );

   tc_register_bank #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b1)) dut1 (
      .clk(clk), .rst(rst), .save(save), .save_addr(save_addr), .in(wdata), .clear(clear),
      .load_a(load_a), .addr_a(addr_a), .out_a(out_a1),
      .load_b(load_b), .addr_b(addr_b), .out_b(out_b1), .wr_count(wr_count1)
   );

   function automatic bit accepts(input bit zr, input logic [2:0] a);
      int depth = zr ? 6 : 8;
      return (int'(a) < depth) && !(zr && a == 3'd0);
   endfunction

   function automatic logic [7:0] exp_rd(input bit zr, input logic ld, input logic [2:0] a);
      if (!ld || !accepts(zr, a)) return 8'h00;
`ifdef TC_REGBANK_BYPASS_EN
      if (!rst && clear) return 8'h00;
      if (!rst && save && accepts(zr, save_addr) && a == save_addr) return wdata;
`endif
      return zr ? m1[a] : m0[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m0[i] = 8'h00;
      for (int i = 0; i < 6; i++) m1[i] = 8'h00;
      c0 = 0;
      c1 = 0;
   endtask

   task automatic model_edge();
      if (clear) begin
         model_reset();
      end else if (save) begin
         m0[save_addr] = wdata;
         c0 = (c0 < 255) ? c0 + 1 : 255;
         if (accepts(1'b1, save_addr)) begin
            m1[save_addr] = wdata;
            c1 = (c1 < 255) ? c1 + 1 : 255;
         end
      end
   endtask

   task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_cycle();
      cmp("model_out_a0", out_a0, exp_rd(1'b0, load_a, addr_a));
      cmp("model_out_b0", out_b0, exp_rd(1'b0, load_b, addr_b));
      cmp("model_wr0", wr_count0, 8'(c0));
      cmp("model_out_a1", out_a1, exp_rd(1'b1, load_a, addr_a));
      cmp("model_out_b1", out_b1, exp_rd(1'b1, load_b, addr_b));
      cmp("model_wr1", wr_count1, 8'(c1));
   endtask

   task automatic tick();
      #1;
      cmp_cycle();
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
   endtask

   task automatic look();
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      save = 1'b1; save_addr = a; wdata = d;
      tick();
      save = 1'b0;
   endtask

   initial begin
      rst = 1'b1; save = 1'b0; clear = 1'b0; save_addr = 3'd0; wdata = 8'h00;
      load_a = 1'b1; load_b = 1'b1; addr_a = 3'd0; addr_b = 3'd0;
      model_reset();
      @(negedge clk);

      // reset: all addresses read zero on both ports
      for (int i = 0; i < 10; i++) begin
         addr_a = 3'(i); addr_b = 3'(7 - (i % 8));
         tick();
      end
      cmp("rst_wr0", wr_count0, 8'h00);
      cmp("rst_out_a0", out_a0, 8'h00);
      rst = 1'b0; load_a = 1'b0; load_b = 1'b0;

      // single write then gated read
      wr(3'd3, 8'hA5);
      load_a = 1'b1; addr_a = 3'd3; look();
      cmp("rd3_a0", out_a0, 8'hA5);
      cmp("rd3_a1", out_a1, 8'hA5);
      cmp("wr_one", wr_count0, 8'h01);
      tick();
      load_a = 1'b0; look();
      cmp("gate_a0", out_a0, 8'h00);
      tick();

      // dual-port reads and swap
      wr(3'd1, 8'h11);
      wr(3'd2, 8'h22);
      load_a = 1'b1; load_b = 1'b1; addr_a = 3'd1; addr_b = 3'd2; look();
      cmp("dual_a", out_a0, 8'h11);
      cmp("dual_b", out_b0, 8'h22);
      tick();
      addr_a = 3'd2; addr_b = 3'd1; look();
      cmp("swap_a", out_a0, 8'h22);
      cmp("swap_b", out_b0, 8'h11);
      tick();
      addr_a = 3'd2; addr_b = 3'd2;
      tick();

      // hardwired zero register and out-of-range write
      wr(3'd0, 8'hFF);
      addr_a = 3'd0; look();
      cmp("r0_ord", out_a0, 8'hFF);
      cmp("r0_zero", out_a1, 8'h00);
      cmp("r0_wr1", wr_count1, 8'h03);
      tick();
      wr(3'd6, 8'h5A);
      addr_a = 3'd6; look();
      cmp("oor_rd0", out_a0, 8'h5A);
      cmp("oor_rd1", out_a1, 8'h00);
      cmp("oor_wr0", wr_count0, 8'h05);
      cmp("oor_wr1", wr_count1, 8'h03);
      tick();

      // clear beats a simultaneous save
      save = 1'b1; clear = 1'b1; save_addr = 3'd4; wdata = 8'h77; addr_a = 3'd4;
      tick();
      save = 1'b0; clear = 1'b0; look();
      cmp("clr_r4", out_a0, 8'h00);
      cmp("clr_wr0", wr_count0, 8'h00);
      cmp("clr_wr1", wr_count1, 8'h00);
      tick();

      // saturation
      for (int i = 0; i < 300; i++) wr(3'(i % 8), 8'(i));
      addr_a = 3'd7; addr_b = 3'd5; look();
      cmp("sat_wr0", wr_count0, 8'hFF);
      cmp("sat_wr1", wr_count1, 8'd188);
      cmp("sat_r7", out_a0, 8'h27);
      cmp("sat_r5", out_b0, 8'h25);
      tick();

      // same-cycle visibility of a write
      save = 1'b1; save_addr = 3'd5; wdata = 8'h3C; addr_a = 3'd5; look();
`ifdef TC_REGBANK_BYPASS_EN
      cmp("fwd_a0", out_a0, 8'h3C);
`else
      cmp("nofwd_a0", out_a0, 8'h25);
`endif
      tick();
      save = 1'b0; look();
      cmp("post_a0", out_a0, 8'h3C);
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      wr(3'd5, 8'h4B);

      // reset asserted in the middle of a write
      save = 1'b1; save_addr = 3'd5; wdata = 8'h99; addr_a = 3'd5;
      #2;
      rst = 1'b1;
      model_reset();
      look();
      cmp("rstmid_a0", out_a0, 8'h00);
      tick();
      rst = 1'b0; save = 1'b0; look();
      cmp("rstlost_a0", out_a0, 8'h00);
      cmp("rstlost_wr0", wr_count0, 8'h00);
      tick();
      wr(3'd2, 8'hC3);
      addr_b = 3'd2; look();
      cmp("first_wr_b0", out_b0, 8'hC3);
      cmp("first_wr_cnt", wr_count0, 8'h01);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
